// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter
//   Shares the single DMI request/response channel (toward the DMI CDC) between
//   two requesters in the JTAG clock domain: port 0 (DTM data-register FSM) and
//   port 1 (auxiliary DMI master). One transaction in flight at a time; every
//   response is routed back to the issuing port; a response timeout keeps a hung
//   debug module from locking the TAP.
//
//   Optional feature macro: DMI_ARB_RR_EN
//     defined   -> round-robin between the two ports
//     undefined -> fixed priority, port 0 wins simultaneous requests
//
//   Ports
//     tck_i, trst_ni                  JTAG clock / async active-low reset
//     reqN_i/_valid_i/_ready_o        port N request (0-cycle accept in Idle only)
//     respN_o/_valid_o/_ready_i       port N response (only the owner's valid is set)
//     dmi_req_o/_valid_o/_ready_i     request toward the CDC
//     dmi_resp_i/_valid_i/_ready_o    response from the CDC
//     busy_o                          not Idle
//     grant_o                         owner of the current transaction
//     timeout_o                       one-cycle pulse when a transaction is aborted

package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_req_arbiter #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          tck_i,
  input  logic          trst_ni,
  input  dm::dmi_req_t  req0_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  output dm::dmi_resp_t resp0_o,
  output logic          resp0_valid_o,
  input  logic          resp0_ready_i,
  input  dm::dmi_req_t  req1_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  output dm::dmi_resp_t resp1_o,
  output logic          resp1_valid_o,
  input  logic          resp1_ready_i,
  output dm::dmi_req_t  dmi_req_o,
  output logic          dmi_req_valid_o,
  input  logic          dmi_req_ready_i,
  input  dm::dmi_resp_t dmi_resp_i,
  input  logic          dmi_resp_valid_i,
  output logic          dmi_resp_ready_o,
  output logic          busy_o,
  output logic          grant_o,
  output logic          timeout_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {Idle, Req, WaitResp, Resp} state_e;

  state_e        state_q, state_d;
  dm::dmi_req_t  req_q, req_d;
  dm::dmi_resp_t resp_q, resp_d;
  logic          grant_q, grant_d;
  logic          stale_q, stale_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic winner;     // port that wins when Idle sees a request
  logic resp_hs;    // owner consumed the response this cycle
  logic stale_drop; // late response from an aborted transaction is discarded

  assign resp_hs = (state_q == Resp) && (grant_q ? resp1_ready_i : resp0_ready_i);

`ifdef DMI_ARB_RR_EN
  // ptr_q names the preferred port; it flips to the non-owner after each
  // completed response so the two ports alternate under contention.
  logic ptr_q, ptr_d;

  assign winner = (req0_valid_i && req1_valid_i) ? ptr_q : ~req0_valid_i;

  always_comb begin
    ptr_d = ptr_q;
    if (resp_hs) ptr_d = ~grant_q;
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`else
  assign winner = ~req0_valid_i;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    resp_d     = resp_q;
    grant_d    = grant_q;
    stale_d    = stale_q;
    cnt_d      = cnt_q;

    req0_ready_o     = 1'b0;
    req1_ready_o     = 1'b0;
    dmi_req_valid_o  = 1'b0;
    resp0_valid_o    = 1'b0;
    resp1_valid_o    = 1'b0;
    timeout_o        = 1'b0;
    // A pending late response is drained in every state so it can never be
    // mistaken for the answer to a later transaction.
    dmi_resp_ready_o = stale_q;

    stale_drop = stale_q && dmi_resp_valid_i;
    if (stale_drop) stale_d = 1'b0;

    unique case (state_q)
      Idle: begin
        // Ready is withheld while reset is asserted: the edge would not latch.
        if (trst_ni && (req0_valid_i || req1_valid_i)) begin
          req0_ready_o = ~winner;
          req1_ready_o = winner;
          req_d        = winner ? req1_i : req0_i;
          grant_d      = winner;
          state_d      = Req;
        end
      end
      Req: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          cnt_d   = '0;
          state_d = WaitResp;
        end
      end
      WaitResp: begin
        dmi_resp_ready_o = 1'b1;
        if (stale_drop) begin
          // The dropped beat belonged to the aborted transaction; give the
          // current one a fresh timeout window.
          cnt_d = '0;
        end else if (dmi_resp_valid_i) begin
          // A real response in the limit cycle still wins over the abort.
          resp_d  = dmi_resp_i;
          state_d = Resp;
        end else if (cnt_q == CntLast) begin
          resp_d.data = '0;
          resp_d.resp = 2'h2;
          timeout_o   = 1'b1;
          stale_d     = 1'b1;
          state_d     = Resp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      Resp: begin
        resp0_valid_o = ~grant_q;
        resp1_valid_o = grant_q;
        if (resp_hs) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      req_q   <= '0;
      resp_q  <= '0;
      grant_q <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      grant_q <= grant_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmi_req_o = req_q;
  assign resp0_o   = resp_q;
  assign resp1_o   = resp_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != Idle);

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Scoreboard bench for dmi_req_arbiter (TimeoutCycles = 8).
// Requester/responder stimulus pushes expectations; a monitor pops and compares.
module tb_dmi_req_arbiter;
  localparam int TC = 8;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  always #5 tck = ~tck;

  dm::dmi_req_t  req0, req1, dmi_req;
  dm::dmi_resp_t resp0, resp1, dmi_resp;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic resp0_valid, resp1_valid, resp0_ready = 0, resp1_ready = 0;
  logic dmi_req_valid, dmi_req_ready = 0, dmi_resp_valid = 0, dmi_resp_ready;
  logic busy, grant, timeout;

  dmi_req_arbiter #(.TimeoutCycles(TC)) dut (
    .tck_i(tck), .trst_ni(trst_n),
    .req0_i(req0), .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .resp0_o(resp0), .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready),
    .req1_i(req1), .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .resp1_o(resp1), .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready),
    .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
    .busy_o(busy), .grant_o(grant), .timeout_o(timeout)
  );

  typedef struct { int s; logic [31:0] data; logic [1:0] resp; } sched_t;
  typedef struct { int port; logic [31:0] data; logic [1:0] resp; bit to; } exp_t;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge tck) cyc <= cyc + 1;

  // stimulus queues and knobs
  dm::dmi_req_t q0[$], q1[$];
  sched_t sched[$];
  int dq[$];
  bit all_valid = 0, rand_rdy = 1, fix_data = 0;
  logic [31:0] fdata = 0;
  logic [1:0]  fresp = 0;
  int dn_hold = 0, dn_low = 0, r0_hold = 0, r1_hold = 0, busy_cnt = 0;

  // reference model state
  bit run = 0, free = 1, prev_to = 0;
  int pref = 0, cur_owner = 0, prev_s = -1000, tcnt = 0, tcnt_total = 0;
  dm::dmi_req_t dn_q[$];
  exp_t exp_q[$];
  int grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic dm::dmi_req_t rnd_req();
    dm::dmi_req_t r;
    r.addr = 7'($urandom_range(0, 127));
    r.op   = 2'($urandom_range(0, 2));
    r.data = $urandom;
    return r;
  endfunction

  // Reference model + downstream responder: arbitration, accept rule, request
  // path and response scheduling. Pushes the expected port response.
  always @(negedge tck) begin : model
    int win, d, s, w;
    bit to;
    logic [31:0] dt;
    logic [1:0]  rs;
    if (run) begin
      chk("busy_o", busy, !free);
      if (!free) chk("grant_o", grant, cur_owner);

      if (free && (req0_valid || req1_valid)) begin
`ifdef DMI_ARB_RR_EN
        win = (req0_valid && req1_valid) ? pref : (req1_valid ? 1 : 0);
`else
        win = req0_valid ? 0 : 1;
`endif
        chk("accept_ready", {req1_ready, req0_ready}, (win == 1) ? 2'b10 : 2'b01);
        grant_log.push_back(req1_ready ? 1 : 0);
        dn_q.push_back(win ? req1 : req0);
        if (win == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        cur_owner = win;
        free = 0;
      end else begin
        chk("no_ready", {req1_ready, req0_ready}, 2'b00);
      end

      if (dmi_req_valid) begin
        if (dn_q.size() == 0) flag("dmi_req_valid unexpected");
        else begin
          chk("dmi_req_o", dmi_req, dn_q[0]);
          if (dmi_req_ready) begin
            void'(dn_q.pop_front());
            d = (dq.size() > 0) ? dq.pop_front() : $urandom_range(1, TC + 5);
            s = cyc + d;
            if (s <= prev_s) s = prev_s + 1;
            // a late beat landing in this WaitResp restarts the timeout window
            w = (prev_to && prev_s >= cyc + 1) ? prev_s + 1 : cyc + 1;
            to = (s > w + TC - 1);
            dt = fix_data ? fdata : $urandom;
            rs = fix_data ? fresp : ($urandom_range(0, 1) ? 2'h0 : 2'h3);
            sched.push_back('{s, dt, rs});
            exp_q.push_back('{cur_owner, to ? 32'h0 : dt, to ? 2'h2 : rs, to});
            prev_s = s;
            prev_to = to;
          end
        end
      end

      if (dmi_resp_valid) begin
        chk("dmi_resp_ready_o", dmi_resp_ready, 1'b1);
        if (dmi_resp_ready) void'(sched.pop_front());
      end

      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        free = 1;
        pref = 1 - cur_owner;
      end
    end
  end

  // Monitor: compares DUT responses against the scoreboard queue.
  always @(negedge tck) begin : monitor
    exp_t e;
    if (run) begin
      if (timeout) begin tcnt++; tcnt_total++; end
      if (resp0_valid && resp1_valid) flag("both resp valids");
      if (resp0_valid || resp1_valid) begin
        if (exp_q.size() == 0) flag("resp valid unexpected");
        else begin
          chk("resp_port", resp1_valid ? 1 : 0, exp_q[0].port);
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            e = exp_q.pop_front();
            chk("resp_data", resp1_valid ? resp1.data : resp0.data, e.data);
            chk("resp_code", resp1_valid ? resp1.resp : resp0.resp, e.resp);
            chk("timeout_pulses", tcnt, e.to);
            tcnt = 0;
          end
        end
      end
    end
  end

  task automatic drive();
    @(posedge tck);
    #1;
    if (busy) busy_cnt++;
    req0_valid = (q0.size() > 0) && (all_valid || $urandom_range(0, 3) != 0);
    req1_valid = (q1.size() > 0) && (all_valid || $urandom_range(0, 3) != 0);
    if (q0.size() > 0) req0 = q0[0]; else req0 = '0;
    if (q1.size() > 0) req1 = q1[0]; else req1 = '0;
    if (dmi_req_valid && dn_hold > 0) begin
      dmi_req_ready = 0; dn_hold--; dn_low++;
    end else dmi_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (resp0_valid && r0_hold > 0) begin resp0_ready = 0; r0_hold--; end
    else resp0_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (resp1_valid && r1_hold > 0) begin resp1_ready = 0; r1_hold--; end
    else resp1_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    dmi_resp_valid = (sched.size() > 0) && (sched[0].s <= cyc);
    if (sched.size() > 0) begin
      dmi_resp.data = sched[0].data;
      dmi_resp.resp = sched[0].resp;
    end else dmi_resp = '0;
  endtask

  task automatic wait_idle(input string ph);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sched.size() > 0 || !free || exp_q.size() > 0)
           && n < 2000) begin
      drive();
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s: still busy after %0d cycles, want idle", ph, n);
    end
  endtask

  initial begin
    dm::dmi_req_t r;
    req0 = '0; req1 = '0; dmi_resp = '0;
    // reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valids", {dmi_req_valid, resp0_valid, resp1_valid, dmi_resp_ready, timeout}, 0);
    chk("rst_data", {dmi_req, resp0, resp1}, 0);
    #10 trst_n = 1;
    run = 1;

    // grants under contention
    all_valid = 1; rand_rdy = 0; grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rnd_req()); q1.push_back(rnd_req());
      dq.push_back(1); dq.push_back(1);
    end
    wait_idle("grants");
    for (int i = 0; i < 4; i++) begin
`ifdef DMI_ARB_RR_EN
      chk("grant_seq", grant_log[i], i % 2);
`else
      chk("grant_seq", grant_log[i], 0);
`endif
    end

    // single port-0 read, answered after 3 waiting cycles
    all_valid = 0; busy_cnt = 0;
    fix_data = 1; fdata = 32'hDEADBEEF; fresp = 2'h0;
    r = '0; r.addr = 7'h11; r.op = 2'h1;
    q0.push_back(r); dq.push_back(4);
    wait_idle("single_read");
    chk("busy_cycles", busy_cnt, 6);
    fix_data = 0;

    // port-1 write with downstream stalled 10 cycles
    r = rnd_req(); r.op = 2'h2;
    dn_low = 0; dn_hold = 10; q1.push_back(r); dq.push_back(2);
    wait_idle("write_stall");
    chk("stall_cycles", dn_low, 10);

    // timeout, late beat dropped in the next WaitResp, next completes
    tcnt_total = 0;
    q0.push_back(rnd_req()); q0.push_back(rnd_req());
    dq.push_back(13); dq.push_back(2);
    all_valid = 1;
    wait_idle("timeout");
    chk("timeout_count", tcnt_total, 1);

    // owner stalls its response 20 cycles while the other port waits
    r0_hold = 20; r1_hold = 20;
    q0.push_back(rnd_req()); q1.push_back(rnd_req());
    wait_idle("resp_stall");

    // randomized traffic
    all_valid = 0; rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 5) == 0) q0.push_back(rnd_req());
      if (q1.size() < 2 && $urandom_range(0, 5) == 0) q1.push_back(rnd_req());
      drive();
    end
    wait_idle("random");

    // reset asserted in WaitResp
    run = 0;
    @(posedge tck); #1;
    r = rnd_req();
    req0 = r; req0_valid = 1; req1_valid = 0; dmi_req_ready = 1; dmi_resp_valid = 0;
    #1 chk("mid_accept", req0_ready, 1);
    @(posedge tck); #1;
    req0_valid = 0;
    chk("mid_req", dmi_req_valid, 1);
    @(posedge tck); #1;
    chk("mid_wait", {busy, dmi_resp_ready}, 2'b11);
    #2 trst_n = 0;
    #1;
    chk("arst_ctrl", {busy, grant, dmi_req_valid, dmi_resp_ready, resp0_valid, resp1_valid, timeout}, 0);
    chk("arst_data", {dmi_req, resp0, resp1}, 0);
    #3 trst_n = 1;
    @(posedge tck); #1;
    r = rnd_req();
    req1 = r; req1_valid = 1;
    #1 chk("post_rst_accept", {req1_ready, req0_ready}, 2'b10);
    @(posedge tck); #1;
    req1_valid = 0;
    chk("post_rst_req", dmi_req, r);
    chk("post_rst_grant", grant, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
